// File: rtl/fifo_pkg.sv
// Shared types and defaults for the single-clock FIFO.
// Holds word/pointer/count typedefs used by fifo_if and the FIFO core.
package fifo_pkg;
  localparam int FIFO_DW        = 32;
  localparam int FIFO_DEPTH     = 256;
  localparam int FIFO_AF_MARGIN = 4;
  localparam int PTR_W          = $clog2(FIFO_DEPTH);

  typedef logic [PTR_W-1:0]   ptr_t;
  typedef logic [PTR_W:0]     cnt_t;
  typedef logic [FIFO_DW-1:0] word_t;
endpackage

// File: rtl/fifo_if.sv
// Signal bundle for single_clk_fifo: clk/reset ports plus FIFO members.
// Modports: dut (FIFO side) and tb (producer/consumer side, mirrored).
interface fifo_if
  import fifo_pkg::*;
(
  input logic clk,
  input logic reset
);
  logic  wr_en;
  word_t wr_data;
  logic  rd_en;
  word_t rd_data;
  logic  valid;
  logic  empty;
  logic  full;
  logic  almost_full;
  cnt_t  count;

  modport dut (
    input  clk, reset,
    input  wr_en, wr_data, rd_en,
    output rd_data, valid, empty,
    output full, almost_full, count
  );

  modport tb (
    input  clk, reset,
    output wr_en, wr_data, rd_en,
    input  rd_data, valid, empty,
    input  full, almost_full, count
  );
endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port synchronous RAM: one write port, one registered read.
// Ports: clk, reset (async low, clears read reg), wr_*, rd_en/rd_addr, rd_data.
module fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  localparam int WORDS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register holds its value when no read is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/single_clk_fifo.sv
// Single-clock FIFO with registered read data, valid strobe and flags.
// Port: bus (fifo_if.dut) carrying clk, reset, wr/rd requests and status.
module single_clk_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DW,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int AF_MARGIN  = FIFO_AF_MARGIN
) (
  fifo_if.dut bus
);
  ptr_t wr_ptr;
  ptr_t rd_ptr;
  cnt_t cnt;
  logic valid_q;
  logic wr_acc;
  logic rd_acc;

  // Flags come straight from the registered count.
  assign bus.empty       = (cnt == '0);
  assign bus.full        = (cnt == cnt_t'(DEPTH));
  assign bus.almost_full = (cnt >= cnt_t'(DEPTH - AF_MARGIN));
  assign bus.count       = cnt;
  assign bus.valid       = valid_q;

  // Full is judged before the read, so no write on a full FIFO.
  assign wr_acc = bus.wr_en & ~bus.full;
  assign rd_acc = bus.rd_en & ~bus.empty;

  always_ff @(posedge bus.clk or negedge bus.reset) begin
    if (!bus.reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      valid_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      valid_q <= rd_acc;
      unique case (1'b1)
        wr_acc & ~rd_acc: cnt <= cnt + 1'b1;
        rd_acc & ~wr_acc: cnt <= cnt - 1'b1;
        default:          cnt <= cnt;
      endcase
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (PTR_W)
  ) u_mem (
    .clk     (bus.clk),
    .reset   (bus.reset),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (bus.wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (bus.rd_data)
  );
endmodule

// File: tb/tb_single_clk_fifo.sv
// Self-checking bench for single_clk_fifo: vector table, directed corners,
// and randomized traffic against a queue-based reference model.
module tb_single_clk_fifo;
  logic clk;
  logic reset;

  fifo_if bus (.clk(clk), .reset(reset));

  single_clk_fifo dut (.bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  logic [31:0] q[$];
  logic [31:0] exp_rd;
  logic        exp_valid;

  typedef struct {
    logic        wr;
    logic [31:0] wd;
    logic        rd;
    logic        ev;
    logic [31:0] erd;
    int          ecnt;
    logic        eempty;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp,
               $time);
    end
  endtask

  task automatic compare_model();
    int n;
    n = q.size();
    chk("valid", 32'(bus.valid), 32'(exp_valid));
    chk("rd_data", bus.rd_data, exp_rd);
    chk("count", 32'(bus.count), 32'(n));
    chk("empty", 32'(bus.empty), 32'(n == 0));
    chk("full", 32'(bus.full), 32'(n == 256));
    chk("almost_full", 32'(bus.almost_full), 32'(n >= 252));
  endtask

  task automatic model_reset();
    q.delete();
    exp_rd    = '0;
    exp_valid = 1'b0;
  endtask

  // One clock: drive, take the edge, update model, sample 1ns later.
  task automatic step(input logic w, input logic [31:0] wd,
                      input logic r);
    bit wacc;
    bit racc;
    bus.wr_en   = w;
    bus.wr_data = wd;
    bus.rd_en   = r;
    @(posedge clk);
    wacc = w && (q.size() < 256);
    racc = r && (q.size() > 0);
    exp_valid = racc;
    if (racc) exp_rd = q.pop_front();
    if (wacc) q.push_back(wd);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.wr_data = '0;
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.wr_data = '0;

    tbl[0] = '{1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1, 1'b0};
    tbl[1] = '{1'b1, 32'h1, 1'b0, 1'b0, 32'h0, 2, 1'b0};
    tbl[2] = '{1'b1, 32'h2, 1'b0, 1'b0, 32'h0, 3, 1'b0};
    tbl[3] = '{1'b1, 32'h3, 1'b0, 1'b0, 32'h0, 4, 1'b0};
    tbl[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 3, 1'b0};
    tbl[5] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h1, 2, 1'b0};
    tbl[6] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h2, 1, 1'b0};
    tbl[7] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h3, 0, 1'b1};
    tbl[8] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h3, 0, 1'b1};

    // Reset state
    #2;
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_af", 32'(bus.almost_full), 32'd0);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_rd_data", bus.rd_data, 32'd0);
    reset = 1'b1;

    // Write four, read four, idle
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].wr, tbl[i].wd, tbl[i].rd);
      chk("tbl_valid", 32'(bus.valid), 32'(tbl[i].ev));
      chk("tbl_rd_data", bus.rd_data, tbl[i].erd);
      chk("tbl_count", 32'(bus.count), 32'(tbl[i].ecnt));
      chk("tbl_empty", 32'(bus.empty), 32'(tbl[i].eempty));
    end

    // Streaming with rd_en held high
    for (int i = 0; i < 255; i++) step(1'b1, 32'(i), 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk("stream_last", bus.rd_data, 32'd254);

    // Fill, overflow drop, drain
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 32'(i), 1'b0);
      if (i == 250) chk("af_251", 32'(bus.almost_full), 32'd0);
      if (i == 251) chk("af_252", 32'(bus.almost_full), 32'd1);
    end
    chk("fill_full", 32'(bus.full), 32'd1);
    step(1'b1, 32'hDEAD, 1'b0);
    chk("drop_count", 32'(bus.count), 32'd256);
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 32'h0, 1'b1);
      chk("drain_word", bus.rd_data, 32'(i));
    end
    step(1'b0, 32'h0, 1'b1);
    chk("drain_empty_valid", 32'(bus.valid), 32'd0);

    // Full with simultaneous write and read
    for (int i = 0; i < 256; i++) step(1'b1, 32'(i), 1'b0);
    step(1'b1, 32'hBEEF, 1'b1);
    chk("fullrw_full", 32'(bus.full), 32'd0);
    chk("fullrw_count", 32'(bus.count), 32'd255);
    chk("fullrw_rd", bus.rd_data, 32'd0);
    chk("fullrw_valid", 32'(bus.valid), 32'd1);

    // Asynchronous reset mid-operation at count=10
    do_reset();
    for (int i = 0; i < 11; i++) step(1'b1, 32'h100 + 32'(i), 1'b0);
    step(1'b0, 32'h0, 1'b1);
    chk("pre_async_count", 32'(bus.count), 32'd10);
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    chk("async_count", 32'(bus.count), 32'd0);
    chk("async_empty", 32'(bus.empty), 32'd1);
    chk("async_valid", 32'(bus.valid), 32'd0);
    chk("async_rd_data", bus.rd_data, 32'd0);
    chk("async_full", 32'(bus.full), 32'd0);
    chk("async_af", 32'(bus.almost_full), 32'd0);
    bus.rd_en = 1'b0;
    #2;
    reset = 1'b1;
    step(1'b0, 32'h0, 1'b1);
    chk("post_rst_valid", 32'(bus.valid), 32'd0);
    step(1'b1, 32'h5A5A_1234, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    chk("post_rst_rt", bus.rd_data, 32'h5A5A_1234);

    // Randomized traffic with alternating fill/drain bias
    for (int i = 0; i < 2800; i++) begin
      int wp;
      int rp;
      wp = ((i / 700) % 2 == 0) ? 75 : 25;
      rp = 100 - wp;
      step($urandom_range(0, 99) < wp, $urandom,
           $urandom_range(0, 99) < rp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
